vc_wrr_arbiter: RTL and testbench
=================================

Name: vc_wrr_arbiter

Overview:
- Weighted round-robin read scheduler for two virtual-channel FIFOs (VC0, VC1) sharing one downstream datapath.
- Generates the FIFO read strobes from FIFO empty flags, per-VC weights and downstream backpressure.
- Muxes the returned FIFO data into a single registered output stream with a valid flag.
- Sits between the VC FIFO bank and the next pipeline stage (link/output FIFO).

Parameters:
- BW16, 16, data width of each VC FIFO and of the output stream.
- W0, 3, max consecutive reads granted to VC0 per round (1..15).
- W1, 1, max consecutive reads granted to VC1 per round (1..15).

Ports:
- clk  input  1  clock.
- reset_L  input  1  synchronous reset, active-low.
- VC0_empty  input  1  VC0 FIFO empty flag.
- VC1_empty  input  1  VC1 FIFO empty flag.
- VC0_data_out  input  BW16  VC0 FIFO read data, valid one cycle after VC0_rd.
- VC1_data_out  input  BW16  VC1 FIFO read data, valid one cycle after VC1_rd.
- down_almost_full  input  1  downstream backpressure; no new read is issued while high.
- VC0_rd  output  1  read strobe to VC0 FIFO.
- VC1_rd  output  1  read strobe to VC1 FIFO.
- arb_data_out  output  BW16  scheduled data word.
- arb_valid  output  1  arb_data_out holds a new word this cycle.
- arb_vc_id  output  1  source VC of the current word (0 = VC0, 1 = VC1).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (reset_L), sampled on the rising edge.
- Reset values: VC0_rd=0, VC1_rd=0, arb_valid=0, arb_data_out=0, arb_vc_id=0, state=IDLE, grant counter=0.
- Strobe generation: VC0_rd and VC1_rd are combinational from state, counter, empty flags and down_almost_full.
- At most one rd strobe is high per cycle.
- A strobe is never high when the corresponding empty flag is high or down_almost_full is high.
- FIFO flags update on the same edge as the read.
- States:
  - IDLE: if VC0 not empty, go to SERVE0; else if VC1 not empty, go to SERVE1.
  - SERVE0: assert VC0_rd whenever VC0 is not empty and down_almost_full=0. Each read increments the counter.
  - SERVE1: same rule for VC1.
- Switching (evaluated every cycle, reads counted including the current cycle):
  - If the counter reaches W0 (SERVE0) or W1 (SERVE1), switch to the other SERVE state if the other VC is not empty. Otherwise stay and clear the counter (new round).
  - If the served VC is empty and the other is not, switch immediately and clear the counter. No idle bubble: the read to the new VC is issued in the same cycle as the switch decision.
  - If both VCs are empty, go to IDLE and clear the counter.
- down_almost_full high: no read is issued, and the state and counter hold.
  - Words already read (1-cycle latency) still emerge, so at most 1 word follows the assertion of down_almost_full.
- Output pipeline:
  - arb_valid(t+1) = VC0_rd(t) | VC1_rd(t).
  - arb_vc_id(t+1) = VC1_rd(t).
  - arb_data_out samples VC0_data_out or VC1_data_out according to arb_vc_id combinationally in cycle t+1 and is registered in the next stage. Net latency from rd strobe to arb_valid is 1 cycle; data is presented with that valid.
  - When arb_valid=0, arb_data_out holds its last value.
- Throughput: 1 word/cycle sustained when data is available and there is no backpressure, including across VC switches.
- Counter width: 4 bits. W0=0 or W1=0 is illegal and is not checked.
- Reset mid-burst: everything returns to reset values on the next edge. A word in flight from the last cycle is dropped, with arb_valid=0 in the cycle after reset is asserted.

Optional Feature:
- Macro: ARB_STRICT_PRIO_EN.
- Defined: VC1 has strict priority; weights W0/W1 are ignored.
  - Any cycle where VC1 is not empty and down_almost_full=0 issues VC1_rd.
  - VC0_rd is issued only when VC1 is empty.
  - The state machine collapses to selecting by VC1_empty.
- Not defined: WRR behaviour as described in Behaviour.

Test Plan:
- Reset: hold reset_L=0 for 3 cycles with both FIFOs non-empty -> VC0_rd=VC1_rd=arb_valid=0, arb_data_out=0.
- Both FIFOs preloaded with 8 words, W0=3, W1=1, down_almost_full=0 -> read order 0,0,0,1,0,0,0,1,...; arb_valid continuously high from the 2nd cycle; arb_vc_id matches the order delayed 1 cycle.
- VC1 empty, VC0 holds 5 words -> 5 consecutive VC0 reads without stalls, then IDLE; arb_valid high for exactly 5 cycles.
- VC0 drains after 2 of 3 grants while VC1 holds 4 -> VC1_rd issued in the very next cycle with no bubble; counter restarts.
- Assert down_almost_full for 4 cycles mid-stream -> no rd strobes in those cycles; exactly 1 trailing arb_valid; resumes with the same VC and counter after deassertion.
- With ARB_STRICT_PRIO_EN defined, both FIFOs holding 4 words -> 4 VC1 reads followed by 4 VC0 reads.

Source files
------------

// File: rtl/vc_wrr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_wrr_arbiter_if : VC FIFO bank <-> arbiter <-> downstream signal bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface vc_wrr_arbiter_if #(
   parameter int BW16 = 16
);
   logic            VC0_empty;
   logic            VC1_empty;
   logic [BW16-1:0] VC0_data_out;
   logic [BW16-1:0] VC1_data_out;
   logic            down_almost_full;
   logic            VC0_rd;
   logic            VC1_rd;
   logic [BW16-1:0] arb_data_out;
   logic            arb_valid;
   logic            arb_vc_id;

   // Arbiter side
   modport master (
      input  VC0_empty, VC1_empty, VC0_data_out, VC1_data_out, down_almost_full,
      output VC0_rd, VC1_rd, arb_data_out, arb_valid, arb_vc_id
   );

   // FIFO bank / downstream side
   modport slave (
      output VC0_empty, VC1_empty, VC0_data_out, VC1_data_out, down_almost_full,
      input  VC0_rd, VC1_rd, arb_data_out, arb_valid, arb_vc_id
   );
endinterface
`default_nettype wire

// File: rtl/vc_wrr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_wrr_arbiter : two-VC weighted round-robin FIFO read scheduler
// Optional macro ARB_STRICT_PRIO_EN gives VC1 strict priority. Revision 1.0
// ---------------------------------------------------------------------------
module vc_wrr_arbiter #(
   parameter int BW16 = 16,
   parameter int W0   = 3,
   parameter int W1   = 1
) (
   input  wire logic          clk,
   input  wire logic          reset_L,
   vc_wrr_arbiter_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [3:0]      cnt;
   logic [3:0]      cnt_nxt;
   logic            rd0;
   logic            rd1;
   logic            valid_q;
   logic            vc_id_q;
   logic [BW16-1:0] data_hold;
   logic [BW16-1:0] data_mux;

`ifdef ARB_STRICT_PRIO_EN
   always_comb begin
      rd1       = reset_L & ~bus.VC1_empty & ~bus.down_almost_full;
      rd0       = reset_L & ~bus.VC0_empty & bus.VC1_empty & ~bus.down_almost_full;
      cnt_nxt   = 4'd0;
      state_nxt = state;
      if (!bus.down_almost_full) begin
         if (!bus.VC1_empty)      state_nxt = SERVE1;
         else if (!bus.VC0_empty) state_nxt = SERVE0;
         else                     state_nxt = IDLE;
      end
   end
`else
   logic       sel1;
   logic       kept;
   logic       oth_ne;
   logic [3:0] base;
   logic [3:0] inc;
   logic [3:0] wsel;

   always_comb begin
      rd0       = 1'b0;
      rd1       = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      // The VC actually served this cycle; an empty served VC hands over
      // immediately so the switch costs no bubble.
      case (state)
         SERVE0:  sel1 = bus.VC0_empty;
         SERVE1:  sel1 = ~bus.VC1_empty;
         default: sel1 = bus.VC0_empty;
      endcase
      kept   = sel1 ? (state == SERVE1) : (state == SERVE0);
      base   = kept ? cnt : 4'd0;
      inc    = base + 4'd1;
      wsel   = sel1 ? 4'(W1) : 4'(W0);
      oth_ne = sel1 ? ~bus.VC0_empty : ~bus.VC1_empty;
      if (bus.down_almost_full) begin
         state_nxt = state;
         cnt_nxt   = cnt;
      end else if (bus.VC0_empty && bus.VC1_empty) begin
         state_nxt = IDLE;
         cnt_nxt   = 4'd0;
      end else begin
         rd1 = reset_L & sel1;
         rd0 = reset_L & ~sel1;
         if (inc >= wsel) begin
            cnt_nxt   = 4'd0;
            state_nxt = (sel1 ^ oth_ne) ? SERVE1 : SERVE0;
         end else begin
            cnt_nxt   = inc;
            state_nxt = sel1 ? SERVE1 : SERVE0;
         end
      end
   end
`endif

   // FIFO data arrives the cycle after the strobe; present it alongside valid.
   always_comb begin
      data_mux = data_hold;
      if (valid_q) data_mux = vc_id_q ? bus.VC1_data_out : bus.VC0_data_out;
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         valid_q   <= 1'b0;
         vc_id_q   <= 1'b0;
         data_hold <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         valid_q   <= rd0 | rd1;
         vc_id_q   <= rd1;
         data_hold <= data_mux;
      end
   end

   assign bus.VC0_rd       = rd0;
   assign bus.VC1_rd       = rd1;
   assign bus.arb_valid    = valid_q;
   assign bus.arb_vc_id    = vc_id_q;
   assign bus.arb_data_out = data_mux;

endmodule
`default_nettype wire

// File: tb/tb_vc_wrr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vc_wrr_arbiter : directed bench with FIFO models and hand-written grant orders
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_vc_wrr_arbiter;

   logic clk = 1'b0;
   logic reset_L;
   int   tests = 0;
   int   fails = 0;
   int   prev  = 0;
   int   wseq  = 0;
   logic [15:0] exp_word = '0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];

   // Grant codes per cycle: 0 = no read, 1 = VC0_rd, 2 = VC1_rd
   int seq_both[17]  = '{1,1,1,2,1,1,1,2,1,1,2,2,2,2,2,2,0};
   int seq_vc0[7]    = '{1,1,1,1,1,0,0};
   int seq_drain[7]  = '{1,1,2,2,2,2,0};
   int seq_resume[6] = '{1,2,1,1,1,2};
   int seq_strict[9] = '{2,2,2,2,1,1,1,1,0};

   vc_wrr_arbiter_if #(.BW16(16)) bus ();

   vc_wrr_arbiter #(.BW16(16), .W0(3), .W1(1)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic sync_flags();
      bus.VC0_empty = (q0.size() == 0);
      bus.VC1_empty = (q1.size() == 0);
   endtask

   task automatic load(input int vc, input int n);
      for (int i = 0; i < n; i++) begin
         wseq++;
         if (vc == 0) q0.push_back(16'hA000 + 16'(wseq));
         else         q1.push_back(16'hB000 + 16'(wseq));
      end
      sync_flags();
   endtask

   task automatic check_cycle(input int code, input string tag);
      logic [1:0] c;
      logic [1:0] rdv;
      logic       s0;
      logic       s1;
      c = 2'(code);
      #1;
      rdv = {bus.VC1_rd, bus.VC0_rd};
      tests++;
      assert (rdv === c) else begin
         fails++;
         $error("FAIL %s rd observed=%b expected=%b", tag, rdv, c);
      end
      tests++;
      assert (bus.arb_valid === (prev != 0)) else begin
         fails++;
         $error("FAIL %s arb_valid observed=%b expected=%b", tag, bus.arb_valid, (prev != 0));
      end
      tests++;
      assert (bus.arb_vc_id === (prev == 2)) else begin
         fails++;
         $error("FAIL %s arb_vc_id observed=%b expected=%b", tag, bus.arb_vc_id, (prev == 2));
      end
      if (prev != 0) begin
         tests++;
         assert (bus.arb_data_out === exp_word) else begin
            fails++;
            $error("FAIL %s arb_data_out observed=%h expected=%h", tag, bus.arb_data_out, exp_word);
         end
      end
      s0 = bus.VC0_rd;
      s1 = bus.VC1_rd;
      @(posedge clk);
      #1;
      if (s0 && q0.size() > 0) begin
         bus.VC0_data_out = q0.pop_front();
         exp_word = bus.VC0_data_out;
      end
      if (s1 && q1.size() > 0) begin
         bus.VC1_data_out = q1.pop_front();
         exp_word = bus.VC1_data_out;
      end
      prev = code;
      sync_flags();
   endtask

   initial begin
      reset_L = 1'b0;
      bus.down_almost_full = 1'b0;
      bus.VC0_data_out = '0;
      bus.VC1_data_out = '0;
`ifdef ARB_STRICT_PRIO_EN
      load(0, 4);
      load(1, 4);
`else
      load(0, 8);
      load(1, 8);
`endif
      @(posedge clk);
      #1;
      repeat (3) check_cycle(0, "reset");
      tests++;
      assert (bus.arb_data_out === 16'h0000) else begin
         fails++;
         $error("FAIL reset arb_data_out observed=%h expected=0000", bus.arb_data_out);
      end
      reset_L = 1'b1;

`ifdef ARB_STRICT_PRIO_EN
      foreach (seq_strict[i]) check_cycle(seq_strict[i], "strict");
`else
      foreach (seq_both[i]) check_cycle(seq_both[i], "wrr_both");

      load(0, 5);
      foreach (seq_vc0[i]) check_cycle(seq_vc0[i], "vc0_only");

      load(0, 2);
      load(1, 4);
      foreach (seq_drain[i]) check_cycle(seq_drain[i], "vc0_drain");

      load(0, 8);
      load(1, 8);
      check_cycle(1, "bp_pre");
      check_cycle(1, "bp_pre");
      bus.down_almost_full = 1'b1;
      repeat (4) check_cycle(0, "bp_hold");
      bus.down_almost_full = 1'b0;
      foreach (seq_resume[i]) check_cycle(seq_resume[i], "bp_resume");

      // Reset mid-burst: the word already registered shows once, then nothing.
      reset_L = 1'b0;
      check_cycle(0, "rst_mid");
      check_cycle(0, "rst_mid");
      tests++;
      assert (bus.arb_data_out === 16'h0000) else begin
         fails++;
         $error("FAIL rst_mid arb_data_out observed=%h expected=0000", bus.arb_data_out);
      end
      reset_L = 1'b1;
      check_cycle(1, "post_rst");
      check_cycle(1, "post_rst");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
